// File: rtl/writeback_ctrl.sv
// Register-file write-back sequencer: latches the write-back mux select and destination,
// waits for the selected source to become valid, then issues a single-cycle RegWrite.
module writeback_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       WB_Req,
    input  logic [3:0] WB_Src,
    input  logic [4:0] WB_Dest,
    input  logic       Mem_Wait,
    input  logic       MultDiv_Busy,
    input  logic       Shift_Busy,
    output logic [3:0] MemToReg,
    output logic       RegWrite,
    output logic [4:0] WriteReg,
    output logic       WB_Ack,
    output logic       WB_Busy,
    output logic       Err_BadSrc,
    output logic       Err_Timeout
);

    typedef enum logic [1:0] {StIdle, StWait, StWrite, StAbort} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       SrcMax  = 4'd9;

    state_e           state_q, state_d;
    logic [3:0]       sel_q, sel_d;
    logic [4:0]       dest_q, dest_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bad_q, bad_d;
    logic             src_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            dest_q  <= '0;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dest_q  <= dest_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
        end
    end

    // Readiness is judged on the latched select, so a changing WB_Src cannot disturb a wait.
    always_comb begin
        src_ready = 1'b1;
        case (sel_q)
            4'd1:       src_ready = !Mem_Wait;
            4'd3, 4'd4: src_ready = !MultDiv_Busy;
            4'd7:       src_ready = !Shift_Busy;
            default:    src_ready = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dest_d  = dest_q;
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        unique case (state_q)
            StIdle: begin
                if (WB_Req) begin
                    if (WB_Src <= SrcMax) begin
                        sel_d   = WB_Src;
                        dest_d  = WB_Dest;
                        cnt_d   = '0;
                        state_d = StWait;
                    end else begin
                        bad_d   = 1'b1;
                        state_d = StAbort;
                    end
                end
            end
            StWait: begin
                if (src_ready) begin
                    state_d = StWrite;
                end else if (cnt_q == CntLast) begin
                    bad_d   = 1'b0;
                    state_d = StAbort;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWrite, StAbort: state_d = StIdle;
            default:          state_d = StIdle;
        endcase
    end

    // Outputs come only from flops; $zero is never written.
    assign MemToReg    = sel_q;
    assign WriteReg    = dest_q;
    assign RegWrite    = (state_q == StWrite) && (dest_q != 5'd0);
    assign WB_Ack      = (state_q == StWrite) || (state_q == StAbort);
    assign WB_Busy     = (state_q != StIdle);
    assign Err_BadSrc  = (state_q == StAbort) && bad_q;
    assign Err_Timeout = (state_q == StAbort) && !bad_q;

endmodule

// File: tb/tb_writeback_ctrl.sv
// Scoreboard bench for writeback_ctrl: the driver pushes expected completions from a
// request-level model; a negedge monitor pops and compares on every WB_Ack.
module tb_writeback_ctrl;

    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned CNT_W   = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       WB_Req = 1'b0;
    logic [3:0] WB_Src = '0;
    logic [4:0] WB_Dest = '0;
    logic       Mem_Wait = 1'b0;
    logic       MultDiv_Busy = 1'b0;
    logic       Shift_Busy = 1'b0;
    logic [3:0] MemToReg;
    logic       RegWrite;
    logic [4:0] WriteReg;
    logic       WB_Ack;
    logic       WB_Busy;
    logic       Err_BadSrc;
    logic       Err_Timeout;

    writeback_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .WB_Req      (WB_Req),
        .WB_Src      (WB_Src),
        .WB_Dest     (WB_Dest),
        .Mem_Wait    (Mem_Wait),
        .MultDiv_Busy(MultDiv_Busy),
        .Shift_Busy  (Shift_Busy),
        .MemToReg    (MemToReg),
        .RegWrite    (RegWrite),
        .WriteReg    (WriteReg),
        .WB_Ack      (WB_Ack),
        .WB_Busy     (WB_Busy),
        .Err_BadSrc  (Err_BadSrc),
        .Err_Timeout (Err_Timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [3:0] sel;
        logic [4:0] wr;
        logic       rw;
        logic       eb;
        logic       et;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    logic [3:0] last_src = '0;
    logic [4:0] last_dest = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n) begin
            if (RegWrite && !WB_Ack) chk("regwrite_without_ack", 32'(RegWrite), 32'd0);
            if (WB_Ack) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_ack", 32'(WB_Ack), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ack_cycle", 32'(cyc), 32'(e.at));
                    chk("memtoreg", 32'(MemToReg), 32'(e.sel));
                    chk("writereg", 32'(WriteReg), 32'(e.wr));
                    chk("regwrite", 32'(RegWrite), 32'(e.rw));
                    chk("err_badsrc", 32'(Err_BadSrc), 32'(e.eb));
                    chk("err_timeout", 32'(Err_Timeout), 32'(e.et));
                    chk("busy_at_ack", 32'(WB_Busy), 32'd1);
                end
            end
        end
    end

    function automatic bit is_gated(input logic [3:0] s);
        return (s == 4'd1) || (s == 4'd3) || (s == 4'd4) || (s == 4'd7);
    endfunction

    task automatic drive_busy(input logic [3:0] s, input bit set_gate, input bit g);
        Mem_Wait     = 1'($urandom_range(0, 1));
        MultDiv_Busy = 1'($urandom_range(0, 1));
        Shift_Busy   = 1'($urandom_range(0, 1));
        if (set_gate) begin
            case (s)
                4'd1:       Mem_Wait = g;
                4'd3, 4'd4: MultDiv_Busy = g;
                4'd7:       Shift_Busy = g;
                default:    ;
            endcase
        end
    endtask

    // Issue one request; gated sources stay busy for d WAIT cycles (forever if stuck).
    // Returns at the negedge of the ack cycle; keep leaves WB_Req high for a chained request.
    task automatic do_req(input logic [3:0] src, input logic [4:0] dest, input int d,
                          input bit stuck, input bit chained, input bit keep);
        exp_t e;
        int   n;
        int   k;
        bit   bad;
        bit   gated;
        bit   done;
        if (!chained) @(negedge clk);
        WB_Req  = 1'b1;
        WB_Src  = src;
        WB_Dest = dest;
        n       = cyc + (chained ? 2 : 1);
        bad     = (src > 4'd9);
        gated   = is_gated(src);
        if (bad) begin
            e = '{sel: last_src, wr: last_dest, rw: 1'b0, eb: 1'b1, et: 1'b0, at: n};
        end else if (gated && stuck) begin
            e = '{sel: src, wr: dest, rw: 1'b0, eb: 1'b0, et: 1'b1, at: n + int'(TIMEOUT)};
        end else begin
            e = '{sel: src, wr: dest, rw: (dest != 5'd0), eb: 1'b0, et: 1'b0,
                  at: n + (gated ? d : 0) + 1};
        end
        if (!bad) begin
            last_src  = src;
            last_dest = dest;
        end
        exp_q.push_back(e);
        drive_busy(src, 1'b0, 1'b0);
        done = 1'b0;
        for (int t = 0; t < int'(TIMEOUT) + 10 && !done; t++) begin
            @(negedge clk);
            k = cyc - n;
            if (WB_Ack && k >= 0) done = 1'b1;
            drive_busy(src, gated && k >= 0, stuck || (k < d));
            if (!done && k >= 0) begin
                chk("hold_select", 32'(MemToReg), 32'(src));
                chk("no_early_write", 32'(RegWrite), 32'd0);
            end
        end
        if (!done) chk("ack_wait_bound", 32'(done), 32'd1);
        if (!keep) WB_Req = 1'b0;
    endtask

    initial begin
        bit prev_keep;
        #1;
        chk("rst_memtoreg", 32'(MemToReg), 32'd0);
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_writereg", 32'(WriteReg), 32'd0);
        chk("rst_ack", 32'(WB_Ack), 32'd0);
        chk("rst_busy", 32'(WB_Busy), 32'd0);
        chk("rst_errs", 32'({Err_BadSrc, Err_Timeout}), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        do_req(4'd0, 5'd5, 0, 1'b0, 1'b0, 1'b0);
        do_req(4'd1, 5'd10, 4, 1'b0, 1'b0, 1'b0);
        do_req(4'd3, 5'd6, 0, 1'b1, 1'b0, 1'b0);
        do_req(4'd12, 5'd4, 0, 1'b0, 1'b0, 1'b0);
        do_req(4'd9, 5'd0, 0, 1'b0, 1'b0, 1'b0);
        do_req(4'd2, 5'd7, 0, 1'b0, 1'b0, 1'b1);
        do_req(4'd8, 5'd9, 0, 1'b0, 1'b1, 1'b0);

        // Reset while waiting kills the write.
        @(negedge clk);
        WB_Req = 1'b1;
        WB_Src = 4'd4;
        WB_Dest = 5'd3;
        MultDiv_Busy = 1'b1;
        @(negedge clk);
        WB_Req = 1'b0;
        chk("pre_reset_busy", 32'(WB_Busy), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_memtoreg", 32'(MemToReg), 32'd0);
        chk("arst_writereg", 32'(WriteReg), 32'd0);
        chk("arst_busy", 32'(WB_Busy), 32'd0);
        chk("arst_ack_rw", 32'({WB_Ack, RegWrite}), 32'd0);
        last_src = '0;
        last_dest = '0;
        @(negedge clk);
        reset_n = 1'b1;
        MultDiv_Busy = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_reset_idle", 32'({WB_Busy, WB_Ack, RegWrite}), 32'd0);
        end

        prev_keep = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic [3:0] s;
            bit kp;
            s  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                             : 4'($urandom_range(0, 9));
            kp = (i != 39) && ($urandom_range(0, 2) == 0);
            do_req(s, 5'($urandom_range(0, 31)), int'($urandom_range(0, 6)),
                   ($urandom_range(0, 11) == 0), prev_keep, kp);
            prev_keep = kp;
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_ctrl.md
# writeback_ctrl

Register-file write-back sequencer for the multicycle MIPS datapath. Accepts one write-back request at a time from the main control unit and drives the 4-bit MemToReg select of the write-back mux. Holds that select stable while the chosen source is not yet valid (memory load, HI/LO from mult/div, shift register), then issues a single-cycle RegWrite. Aborts with an error flag on an illegal source code or a wait timeout.

## Interface
- TIMEOUT, 64: maximum WAIT cycles before abort (≥2).
- CNT_W, 8: width of the wait counter; 2^CNT_W must exceed TIMEOUT.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- WB_Req  in  1  write-back request; held high with WB_Src/WB_Dest stable until WB_Ack.
- WB_Src  in  4  source code: 0 ALUOut, 1 LSControl_Out, 2 Imm_SL16, 3 HI_Out, 4 LO_Out, 5 constant 227, 6 Imm_SignExt, 7 ShiftReg_Out, 8 B_Out, 9 A_Out.
- WB_Dest  in  5  destination register number.
- Mem_Wait  in  1  load data not yet valid (gates source 1).
- MultDiv_Busy  in  1  HI/LO not yet valid (gates sources 3, 4).
- Shift_Busy  in  1  shift register not yet valid (gates source 7).
- MemToReg  out  4  write-back mux select.
- RegWrite  out  1  register-file write enable.
- WriteReg  out  5  register-file write address.
- WB_Ack  out  1  one-cycle completion pulse (success or abort).
- WB_Busy  out  1  request in progress.
- Err_BadSrc  out  1  one-cycle pulse with WB_Ack: WB_Src > 9.
- Err_Timeout  out  1  one-cycle pulse with WB_Ack: source not ready within TIMEOUT cycles.

## Operation
- States: IDLE, WAIT, WRITE, ABORT. All outputs are registered or decoded from state flops only; no input-to-output combinational path.
- IDLE: samples WB_Req.
  - WB_Src ≤ 9: latch WB_Src→MemToReg and WB_Dest→WriteReg, clear the counter, go to WAIT.
  - WB_Src > 9: leave MemToReg/WriteReg unchanged, go to ABORT with Err_BadSrc.
- WAIT: ready = (src 1: !Mem_Wait) | (src 3,4: !MultDiv_Busy) | (src 7: !Shift_Busy) | (all other sources: 1).
  - Ready: go to WRITE.
  - Not ready and counter == TIMEOUT−1: go to ABORT with Err_Timeout.
  - Otherwise: counter++.
  - Ready takes priority over timeout in the same cycle.
- WRITE: RegWrite=1 and WB_Ack=1 for exactly one cycle, then IDLE. If WriteReg == 0, RegWrite stays 0 ($zero is never written) but WB_Ack still pulses.
- ABORT: WB_Ack=1 plus the matching error flag for one cycle, RegWrite=0, then IDLE.
- Busy and ack signals:
  - WB_Busy=1 in WAIT, WRITE, ABORT.
  - MemToReg and WriteReg hold their values from acceptance through WRITE/ABORT and keep them in IDLE until the next acceptance.
- Request handling:
  - Ready inputs are ignored outside WAIT.
  - WB_Req is ignored outside IDLE.
  - WB_Req still high in the IDLE cycle after WB_Ack is a new request.

## Timing
- Reset (async, immediate): state IDLE, MemToReg=0, RegWrite=0, WriteReg=0, WB_Ack=0, WB_Busy=0, Err_BadSrc=0, Err_Timeout=0, counter=0. Reset during WAIT/WRITE kills the write; RegWrite drops without waiting for a clock edge.
- Request accepted at edge N; MemToReg valid from edge N (one full cycle of mux settling before the write).
- Always-ready source: WAIT in cycle N..N+1, WRITE (RegWrite, WB_Ack) in cycle N+1..N+2, IDLE at N+2. Minimum 3 cycles per request (IDLE, WAIT, WRITE).
- Ready source deasserts its busy signal in WAIT cycle k (0-based) → WRITE in cycle k+1.
- Never ready → ABORT in cycle TIMEOUT after acceptance; WB_Ack at latency TIMEOUT+1.
- Bad source: ABORT in the cycle after acceptance (WB_Ack 1 cycle after the request is sampled).

## Test plan
- Reset, then WB_Req with WB_Src=0, WB_Dest=5: MemToReg=0 and WriteReg=5 one edge later; RegWrite=1 and WB_Ack=1 together for one cycle, two edges after the request.
- WB_Src=1, Mem_Wait high for 4 cycles after acceptance: MemToReg=1 held throughout; RegWrite exactly once, in the cycle after Mem_Wait falls; no RegWrite while Mem_Wait=1.
- WB_Src=3, MultDiv_Busy stuck high, TIMEOUT=64: WB_Ack and Err_Timeout together in cycle 64 after acceptance; RegWrite never asserted; next request is accepted normally.
- WB_Src=12: Err_BadSrc and WB_Ack one cycle after the request; MemToReg unchanged; RegWrite=0. Then WB_Src=9, WB_Dest=0: WB_Ack pulses, RegWrite stays 0.
- Back-to-back: WB_Req held high across WB_Ack, with WB_Src changed 2→8 and WB_Dest 7→9 on the ack edge: two writes, to 7 (select 2) then 9 (select 8), 3 cycles apart.
- reset_n pulsed low while in WAIT (WB_Src=4, MultDiv_Busy=1): all outputs zero immediately; no RegWrite after release even when MultDiv_Busy falls.
